// File: rtl/stdp_pkg.sv
// Shared types, constants and helpers for the STDP weight-update controller.
`default_nettype none

package stdp_pkg;

  // Bit positions inside the one-hot STDP case vector
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    MINUS   = 2'd1,
    SEARCH  = 2'd2,
    BACKOFF = 2'd3
  } stdp_case_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EVAL = 2'd2,
    S_FIN  = 2'd3
  } stdp_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR_TAP = 16'hB400;

  function automatic int unsigned wmax(input int unsigned wres);
    return (32'd1 << wres) - 32'd1;
  endfunction

  function automatic logic is_ns(input logic [31:0] t, input int unsigned tres);
    logic [31:0] m;
    m = (32'd1 << tres) - 32'd1;
    return (t & m) == m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stdp_mem_if.sv
// Weight-memory port owned by the controller during an update pass.
`default_nettype none

interface stdp_mem_if #(
  parameter int AW   = 5,
  parameter int WRES = 3
);
  logic [AW-1:0]   w_addr;
  logic            w_rd_en;
  logic [WRES-1:0] w_rdata;
  logic            w_we;
  logic [WRES-1:0] w_wdata;

  modport master (output w_addr, output w_rd_en, input w_rdata, output w_we, output w_wdata);
  modport slave  (input w_addr, input w_rd_en, output w_rdata, input w_we, input w_wdata);
endinterface

`default_nettype wire

// File: rtl/stdp_brv_gen.sv
// Six Galois LFSRs and threshold comparators producing the STDP Bernoulli variables.
`default_nettype none

module stdp_brv_gen
  import stdp_pkg::*;
#(
  parameter int            LW        = 16,
  parameter int            WRES      = 3,
  parameter logic [LW-1:0] SEED      = 16'hACE1,
  parameter logic [LW-1:0] U_CAPTURE = 16'hC000,
  parameter logic [LW-1:0] U_MINUS   = 16'h4000,
  parameter logic [LW-1:0] U_SEARCH  = 16'h0400,
  parameter logic [LW-1:0] U_BACKOFF = 16'hC000,
  parameter logic [LW-1:0] U_MIN     = 16'h1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic [WRES-1:0] w,
  input  logic            fout_up,
  output logic            brv_capture,
  output logic            brv_minus,
  output logic            brv_search,
  output logic            brv_backoff,
  output logic            brv_min,
  output logic            brv_fout
);
  localparam int              NL     = 6;
  localparam logic [LW-1:0]   TAP    = LW'(LFSR_TAP);
  localparam logic [WRES-1:0] WMAX_W = WRES'(wmax(WRES));

  logic [LW-1:0]   lfsr [NL];
  logic [WRES-1:0] fout_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NL; k++) lfsr[k] <= SEED ^ LW'(k + 1);
    end else if (step) begin
      for (int k = 0; k < NL; k++) lfsr[k] <= (lfsr[k] >> 1) ^ (lfsr[k][0] ? TAP : '0);
    end
  end

  assign brv_capture = (lfsr[0] <= U_CAPTURE);
  assign brv_minus   = (lfsr[1] <= U_MINUS);
  assign brv_search  = (lfsr[2] <= U_SEARCH);
  assign brv_backoff = (lfsr[3] <= U_BACKOFF);
  assign brv_min     = (lfsr[4] <= U_MIN);

  // Potentiation is likelier for heavy weights, depression for light ones
  assign fout_lim = fout_up ? w : (WMAX_W - w);
  assign brv_fout = (lfsr[5][WRES-1:0] < fout_lim);

endmodule

`default_nettype wire

// File: rtl/stdp_incdec.sv
// Increment/decrement decision cell: combines the STDP case with its BRVs.
`default_nettype none

module stdp_incdec
  import stdp_pkg::*;
(
  input  logic [3:0] cases,
  input  logic       brv_capture,
  input  logic       brv_minus,
  input  logic       brv_search,
  input  logic       brv_backoff,
  input  logic       brv_min,
  input  logic       brv_fout,
  output logic       inc,
  output logic       dec
);
  logic gate;

  // brv_min keeps a floor on update probability when the weight-dependent term is small
  assign gate = brv_fout | brv_min;
  assign inc  = (cases[CAPTURE] & brv_capture & gate) | (cases[SEARCH] & brv_search);
  assign dec  = (cases[MINUS] & brv_minus & gate) | (cases[BACKOFF] & brv_backoff & gate);

endmodule

`default_nettype wire

// File: rtl/stdp_update_ctrl.sv
// STDP update sequencer: walks every synapse, reads, decides and writes back the weight.
// Optional STDP_STATS_EN adds saturating inc_count/dec_count write counters.
`default_nettype none

module stdp_update_ctrl
  import stdp_pkg::*;
#(
  parameter int            P         = 8,
  parameter int            Q         = 4,
  parameter int            WRES      = 3,
  parameter int            TRES      = 3,
  parameter int            LW        = 16,
  parameter logic [LW-1:0] U_CAPTURE = 16'hC000,
  parameter logic [LW-1:0] U_MINUS   = 16'h4000,
  parameter logic [LW-1:0] U_SEARCH  = 16'h0400,
  parameter logic [LW-1:0] U_BACKOFF = 16'hC000,
  parameter logic [LW-1:0] U_MIN     = 16'h1000,
  parameter logic [LW-1:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [P*TRES-1:0] in_time,
  input  logic [Q*TRES-1:0] out_time,
  output logic              busy,
  output logic              done,
  stdp_mem_if.master        mem
`ifdef STDP_STATS_EN
  ,
  output logic [15:0]       inc_count,
  output logic [15:0]       dec_count
`endif
);
  localparam int              AW     = $clog2(P * Q);
  localparam int              PW     = (P > 1) ? $clog2(P) : 1;
  localparam int              QW     = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [WRES-1:0] WMAX_W = WRES'(wmax(WRES));

  stdp_state_e       state, state_n;
  logic [PW-1:0]     p_idx;
  logic [QW-1:0]     q_idx;
  logic [P*TRES-1:0] lat_in;
  logic [Q*TRES-1:0] lat_out;
  logic [TRES-1:0]   x, y;
  logic              x_ns, y_ns;
  logic [3:0]        cases;
  logic [WRES-1:0]   w;
  logic              last, accept, step, we_inc, we_dec, inc, dec;
  logic              brv_capture, brv_minus, brv_search, brv_backoff, brv_min, brv_fout;

  assign w    = mem.w_rdata;
  assign x    = lat_in[32'(p_idx) * TRES +: TRES];
  assign y    = lat_out[32'(q_idx) * TRES +: TRES];
  assign x_ns = is_ns(32'(x), TRES);
  assign y_ns = is_ns(32'(y), TRES);
  assign last = (32'(p_idx) == P - 1) && (32'(q_idx) == Q - 1);

  always_comb begin
    cases          = '0;
    cases[CAPTURE] = !x_ns && !y_ns && (x <= y);
    cases[MINUS]   =  x_ns && !y_ns;
    cases[SEARCH]  = !x_ns &&  y_ns;
    cases[BACKOFF] = !x_ns && !y_ns && (x > y);
  end

  stdp_brv_gen #(
    .LW(LW), .WRES(WRES), .SEED(SEED),
    .U_CAPTURE(U_CAPTURE), .U_MINUS(U_MINUS), .U_SEARCH(U_SEARCH),
    .U_BACKOFF(U_BACKOFF), .U_MIN(U_MIN)
  ) u_brv (
    .clk(clk), .rst_n(rst_n), .step(step), .w(w), .fout_up(cases[CAPTURE]),
    .brv_capture(brv_capture), .brv_minus(brv_minus), .brv_search(brv_search),
    .brv_backoff(brv_backoff), .brv_min(brv_min), .brv_fout(brv_fout)
  );

  stdp_incdec u_incdec (
    .cases(cases),
    .brv_capture(brv_capture), .brv_minus(brv_minus), .brv_search(brv_search),
    .brv_backoff(brv_backoff), .brv_min(brv_min), .brv_fout(brv_fout),
    .inc(inc), .dec(dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    we_inc      = 1'b0;
    we_dec      = 1'b0;
    mem.w_rd_en = 1'b0;
    mem.w_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RD;
        end
      end
      S_RD: begin
        busy        = 1'b1;
        mem.w_rd_en = 1'b1;
        state_n     = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        step = 1'b1;
        if (inc && (w < WMAX_W)) begin
          we_inc      = 1'b1;
          mem.w_wdata = w + WRES'(1);
        end else if (dec && (w != '0)) begin
          we_dec      = 1'b1;
          mem.w_wdata = w - WRES'(1);
        end
        state_n = last ? S_FIN : S_RD;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem.w_we   = we_inc | we_dec;
  assign mem.w_addr = AW'(32'(q_idx) * P + 32'(p_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_idx   <= '0;
      q_idx   <= '0;
      lat_in  <= '1;
      lat_out <= '1;
    end else if (accept) begin
      p_idx   <= '0;
      q_idx   <= '0;
      lat_in  <= in_time;
      lat_out <= out_time;
    end else if (step) begin
      if (32'(p_idx) == P - 1) begin
        p_idx <= '0;
        q_idx <= last ? '0 : q_idx + QW'(1);
      end else begin
        p_idx <= p_idx + PW'(1);
      end
    end
  end

`ifdef STDP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_count <= '0;
      dec_count <= '0;
    end else if (accept) begin
      inc_count <= '0;
      dec_count <= '0;
    end else begin
      if (we_inc && (inc_count != 16'hFFFF)) inc_count <= inc_count + 16'd1;
      if (we_dec && (dec_count != 16'hFFFF)) dec_count <= dec_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stdp_update_ctrl.sv
// Self-checking bench: three controllers (all-fire, never-fire, default thresholds) run in lockstep.
`default_nettype none
`timescale 1ns/1ps

module tb_stdp_update_ctrl;
  localparam int P = 8, Q = 4, WRES = 3, TRES = 3, LW = 16, N = P * Q, ND = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic logic [15:0] uval(input int d, input int i);
    if (d == 0) return 16'hFFFF;
    if (d == 1) return 16'h0000;
    case (i)
      0: return 16'hC000;
      1: return 16'h4000;
      2: return 16'h0400;
      3: return 16'hC000;
      default: return 16'h1000;
    endcase
  endfunction

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ld = 1'b0;
  logic [P*TRES-1:0] in_time = '1;
  logic [Q*TRES-1:0] out_time = '1;
  logic [ND-1:0] busy_v, done_v, rd_v, we_v;
  logic [4:0]  addr_v  [ND];
  logic [2:0]  wdata_v [ND];
  logic [2:0]  rdata_v [ND];
  logic [15:0] incc_v  [ND];
  logic [15:0] decc_v  [ND];

  logic [2:0] mem    [ND][N];
  logic [2:0] ld_mem [ND][N];
  int         wr_cnt [ND];

  logic [15:0] ml   [ND][6];
  logic [2:0]  emem [ND][N];
  int exp_inc [ND], exp_dec [ND];
  logic [P*TRES-1:0] lat_in;
  logic [Q*TRES-1:0] lat_out;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    stdp_mem_if #(.AW(5), .WRES(WRES)) mif ();
    stdp_update_ctrl #(
      .P(P), .Q(Q), .WRES(WRES), .TRES(TRES), .LW(LW),
      .U_CAPTURE(uval(d, 0)), .U_MINUS(uval(d, 1)), .U_SEARCH(uval(d, 2)),
      .U_BACKOFF(uval(d, 3)), .U_MIN(uval(d, 4)), .SEED(SEED)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_time(in_time), .out_time(out_time),
      .busy(busy_v[d]), .done(done_v[d]), .mem(mif)
`ifdef STDP_STATS_EN
      , .inc_count(incc_v[d]), .dec_count(decc_v[d])
`endif
    );
    assign addr_v[d]    = mif.w_addr;
    assign rd_v[d]      = mif.w_rd_en;
    assign we_v[d]      = mif.w_we;
    assign wdata_v[d]   = mif.w_wdata;
    assign mif.w_rdata  = rdata_v[d];
`ifndef STDP_STATS_EN
    assign incc_v[d] = 16'd0;
    assign decc_v[d] = 16'd0;
`endif
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (ld) begin
        for (int a = 0; a < N; a++) mem[d][a] <= ld_mem[d][a];
        wr_cnt[d] <= 0;
      end else begin
        if (rd_v[d]) rdata_v[d] <= mem[d][addr_v[d]];
        if (we_v[d]) begin
          mem[d][addr_v[d]] <= wdata_v[d];
          wr_cnt[d] <= wr_cnt[d] + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < 6; k++) ml[d][k] = SEED ^ 16'(k + 1);
  endtask

  task automatic model_run(input int nsyn);
    int p, q, x, y, w, f, a;
    bit xn, yn, cap, mns, srch, bck, fo, up, dn, g;
    for (int s = 0; s < nsyn; s++) begin
      p = s % P; q = s / P; a = q * P + p;
      x = int'(lat_in[p*TRES +: TRES]);
      y = int'(lat_out[q*TRES +: TRES]);
      xn = (x == 7); yn = (y == 7);
      cap = !xn && !yn && (x <= y); mns = xn && !yn;
      srch = !xn && yn;             bck = !xn && !yn && (x > y);
      for (int d = 0; d < ND; d++) begin
        w  = int'(emem[d][a]);
        f  = int'(ml[d][5] & 16'h7);
        fo = cap ? (f < w) : (f < 7 - w);
        g  = fo || (ml[d][4] <= uval(d, 4));
        up = (cap && (ml[d][0] <= uval(d, 0)) && g) || (srch && (ml[d][2] <= uval(d, 2)));
        dn = (mns && (ml[d][1] <= uval(d, 1)) && g) || (bck && (ml[d][3] <= uval(d, 3)) && g);
        if (up && w < 7) begin emem[d][a] = 3'(w + 1); exp_inc[d]++; end
        else if (dn && w > 0) begin emem[d][a] = 3'(w - 1); exp_dec[d]++; end
        for (int k = 0; k < 6; k++) ml[d][k] = lstep(ml[d][k]);
      end
    end
  endtask

  function automatic logic [2:0] rtime();
    return ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
  endfunction

  task automatic preload(input int mode, input logic [2:0] v);
    for (int d = 0; d < ND; d++)
      for (int a = 0; a < N; a++) begin
        ld_mem[d][a] = (mode == 0) ? v : 3'($urandom_range(0, 7));
        emem[d][a]   = ld_mem[d][a];
      end
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  // Drives one pass; poke_cyc>0 re-asserts start mid-pass, abort_cyc>0 pulls reset.
  task automatic run_pass(input string name, input int poke_cyc, input bit fin_poke, input int abort_cyc);
    int cyc, base [ND], bad;
    logic [ND-1:0] seen;
    for (int d = 0; d < ND; d++) begin base[d] = wr_cnt[d]; exp_inc[d] = 0; exp_dec[d] = 0; end
    @(negedge clk); start = 1'b1;
    @(posedge clk); lat_in = in_time; lat_out = out_time;
    @(negedge clk); start = 1'b0; cyc = 1; seen = '0;
    checks++;
    if (busy_v !== '1) begin errors++; $display("FAIL %s busy_after_accept: got %b, expected 111", name, busy_v); end
`ifdef STDP_STATS_EN
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (incc_v[d] !== 16'd0 || decc_v[d] !== 16'd0) begin
        errors++; $display("FAIL %s stats_clear dut%0d: got inc=%0d dec=%0d, expected 0/0", name, d, incc_v[d], decc_v[d]);
      end
    end
`endif
    while (seen != '1 && cyc < 200) begin
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        for (int i = 0; i < P; i++) in_time[i*TRES +: TRES] = rtime();
        for (int i = 0; i < Q; i++) out_time[i*TRES +: TRES] = rtime();
        start = 1'b1;
      end else if (poke_cyc != 0 && cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        rst_n = 1'b0; #1;
        for (int c = 0; c < 8; c++) begin
          checks++;
          if ({busy_v, done_v, we_v} !== '0) begin
            errors++; $display("FAIL %s abort_quiet c%0d: got busy=%b done=%b we=%b, expected all 0", name, c, busy_v, done_v, we_v);
          end
          @(negedge clk);
          if (c == 2) rst_n = 1'b1;
        end
        model_run((abort_cyc - 1) / 2);
        model_reset();
        break;
      end
      for (int d = 0; d < ND; d++)
        if (done_v[d] === 1'b1 && !seen[d]) begin
          seen[d] = 1'b1; checks++;
          if (cyc != 2 * N + 1) begin errors++; $display("FAIL %s latency dut%0d: got %0d cycles, expected %0d", name, d, cyc, 2 * N + 1); end
        end
      if (seen != '1) begin @(posedge clk); @(negedge clk); cyc++; end
    end
    if (abort_cyc == 0) begin
      if (seen != '1) begin
        checks++; errors++; $display("FAIL %s done_timeout: got seen=%b, expected 111", name, seen);
      end
      if (fin_poke) start = 1'b1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      checks++;
      if ({busy_v, done_v} !== '0) begin errors++; $display("FAIL %s after_done: got busy=%b done=%b, expected 0/0", name, busy_v, done_v); end
      model_run(N);
    end
    for (int d = 0; d < ND; d++) begin
      bad = -1;
      for (int a = N - 1; a >= 0; a--) if (mem[d][a] !== emem[d][a]) bad = a;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL %s weights dut%0d addr %0d: got %0d, expected %0d", name, d, bad, mem[d][bad], emem[d][bad]); end
      checks++;
      if (wr_cnt[d] - base[d] != exp_inc[d] + exp_dec[d]) begin
        errors++; $display("FAIL %s write_count dut%0d: got %0d, expected %0d", name, d, wr_cnt[d] - base[d], exp_inc[d] + exp_dec[d]);
      end
`ifdef STDP_STATS_EN
      checks++;
      if (incc_v[d] !== 16'(exp_inc[d]) || decc_v[d] !== 16'(exp_dec[d])) begin
        errors++; $display("FAIL %s stats dut%0d: got inc=%0d dec=%0d, expected %0d/%0d", name, d, incc_v[d], decc_v[d], exp_inc[d], exp_dec[d]);
      end
`endif
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({busy_v[d], done_v[d], rd_v[d], we_v[d]} !== 4'b0) begin
        errors++; $display("FAIL reset_ctrl dut%0d: got busy/done/rd/we=%b%b%b%b, expected 0000", d, busy_v[d], done_v[d], rd_v[d], we_v[d]);
      end
      checks++;
      if (addr_v[d] !== 5'd0 || wdata_v[d] !== 3'd0) begin
        errors++; $display("FAIL reset_bus dut%0d: got addr=%0d wdata=%0d, expected 0/0", d, addr_v[d], wdata_v[d]);
      end
      checks++;
      if (incc_v[d] !== 16'd0 || decc_v[d] !== 16'd0) begin
        errors++; $display("FAIL reset_stats dut%0d: got %0d/%0d, expected 0/0", d, incc_v[d], decc_v[d]);
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_capture_inc();
    preload(0, 3'd3);
    in_time = {P{3'd1}}; out_time = {Q{3'd2}};
    run_pass("capture", 0, 1'b0, 0);
    for (int a = 0; a < N; a++) begin
      checks++;
      if (mem[0][a] !== 3'd4) begin errors++; $display("FAIL capture_all_fire addr %0d: got %0d, expected 4", a, mem[0][a]); end
      checks++;
      if (mem[1][a] !== 3'd3) begin errors++; $display("FAIL capture_never_fire addr %0d: got %0d, expected 3", a, mem[1][a]); end
    end
`ifdef STDP_STATS_EN
    checks++;
    if (incc_v[0] !== 16'd32 || decc_v[0] !== 16'd0) begin
      errors++; $display("FAIL capture_stats: got inc=%0d dec=%0d, expected 32/0", incc_v[0], decc_v[0]);
    end
`endif
  endtask

  task automatic test_minus_row();
    preload(0, 3'd3);
    in_time = {P{3'd7}}; out_time = {3'd7, 3'd7, 3'd7, 3'd0};
    run_pass("minus_row", 0, 1'b0, 0);
    for (int a = 0; a < N; a++) begin
      checks++;
      if (mem[0][a] !== ((a < P) ? 3'd2 : 3'd3)) begin
        errors++; $display("FAIL minus_row addr %0d: got %0d, expected %0d", a, mem[0][a], (a < P) ? 2 : 3);
      end
    end
  endtask

  task automatic test_saturation();
    preload(0, 3'd7);
    in_time = {P{3'd0}}; out_time = {Q{3'd5}};
    run_pass("sat_high", 0, 1'b0, 0);
    checks++;
    if (wr_cnt[0] !== 0) begin errors++; $display("FAIL sat_high_writes: got %0d, expected 0", wr_cnt[0]); end
    preload(0, 3'd0);
    in_time = {P{3'd7}};
    run_pass("sat_low", 0, 1'b0, 0);
    checks++;
    if (wr_cnt[0] !== 0) begin errors++; $display("FAIL sat_low_writes: got %0d, expected 0", wr_cnt[0]); end
  endtask

  task automatic test_start_while_busy();
    preload(1, 3'd0);
    for (int i = 0; i < P; i++) in_time[i*TRES +: TRES] = rtime();
    for (int i = 0; i < Q; i++) out_time[i*TRES +: TRES] = rtime();
    run_pass("busy_start", 10, 1'b1, 0);
  endtask

  task automatic test_abort();
    preload(1, 3'd0);
    in_time = {P{3'd2}}; out_time = {Q{3'd4}};
    run_pass("abort", 0, 1'b0, 20);
    for (int i = 0; i < P; i++) in_time[i*TRES +: TRES] = rtime();
    for (int i = 0; i < Q; i++) out_time[i*TRES +: TRES] = rtime();
    run_pass("after_abort", 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) preload(1, 3'd0);
      for (int i = 0; i < P; i++) in_time[i*TRES +: TRES] = rtime();
      for (int i = 0; i < Q; i++) out_time[i*TRES +: TRES] = rtime();
      run_pass("random", 0, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_capture_inc();
    test_minus_row();
    test_saturation();
    test_start_while_busy();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
